// File: rtl/hazard_stall_unit.sv
// Stall unit for the 5-stage pipeline: RAW hazards forwarding cannot cover, MEM-stage SRAM wait FSM, stall counters.
// hazard_stall/mem_freeze are combinational (0 cycles); memory freeze dominates, and the FSM never aborts a wait.
module hazard_stall_unit #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fwd_en,
    input  logic             id_valid,
    input  logic [3:0]       src1,
    input  logic [3:0]       src2,
    input  logic             two_src,
    input  logic [3:0]       EXE_Dest,
    input  logic             EXE_WB_en,
    input  logic             EXE_MEM_R_en,
    input  logic [3:0]       MEM_Dest,
    input  logic             MEM_WB_en,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             hazard_stall,
    output logic             mem_freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] hz_cycles,
    output logic [CNT_W-1:0] mw_cycles
);

    localparam int WC_W = $clog2(TIMEOUT) + 1;
    localparam logic [WC_W-1:0] WC_MAX  = WC_W'(TIMEOUT);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [WC_W-1:0] wait_cnt;
    logic [WC_W-1:0] wait_cnt_nxt;
    logic            freeze;
    logic            timeout_hit;

    logic m1e;
    logic m2e;
    logic m1m;
    logic m2m;
    logic raw;

    // Operand match terms against the two in-flight producers
    always_comb begin
        m1e = EXE_WB_en && (src1 == EXE_Dest);
        m2e = two_src && EXE_WB_en && (src2 == EXE_Dest);
        m1m = MEM_WB_en && (src1 == MEM_Dest);
        m2m = two_src && MEM_WB_en && (src2 == MEM_Dest);
    end

    // With forwarding only a load in EXE is unresolvable (its data arrives after MEM)
    always_comb begin
        if (fwd_en) begin
            raw = id_valid && EXE_MEM_R_en && (m1e || m2e);
        end else begin
            raw = id_valid && (m1e || m2e || m1m || m2m);
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        freeze       = 1'b0;
        timeout_hit  = 1'b0;
        case (state)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    freeze       = 1'b1;
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = WC_W'(1);
                end
            end
            MEM_WAIT: begin
                // mem_req is not re-sampled here: the frozen pipeline keeps it asserted
                if (mem_ready) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else begin
                    freeze      = 1'b1;
                    timeout_hit = (wait_cnt == WC_LAST);
                    if (wait_cnt != WC_MAX) begin
                        wait_cnt_nxt = wait_cnt + WC_W'(1);
                    end
                end
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    assign mem_freeze   = freeze && !rst;
    assign hazard_stall = raw && !freeze && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Sticky until reset; the wait itself continues after a timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_timeout <= 1'b0;
        end else if (timeout_hit) begin
            mem_timeout <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hz_cycles <= '0;
            mw_cycles <= '0;
        end else begin
            if (hazard_stall && (hz_cycles != CNT_SAT)) begin
                hz_cycles <= hz_cycles + CNT_W'(1);
            end
            if (mem_freeze && (mw_cycles != CNT_SAT)) begin
                mw_cycles <= mw_cycles + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: vector table, directed wait/timeout/reset sequences, random run vs reference model.
module tb_hazard_stall_unit;

    localparam int TO   = 4;
    localparam int CW   = 8;
    localparam int CMAX = 255;

    logic          clk = 1'b0;
    logic          rst;
    logic          fwd_en;
    logic          id_valid;
    logic [3:0]    src1;
    logic [3:0]    src2;
    logic          two_src;
    logic [3:0]    EXE_Dest;
    logic          EXE_WB_en;
    logic          EXE_MEM_R_en;
    logic [3:0]    MEM_Dest;
    logic          MEM_WB_en;
    logic          mem_req;
    logic          mem_ready;
    logic          hazard_stall;
    logic          mem_freeze;
    logic          mem_timeout;
    logic [CW-1:0] hz_cycles;
    logic [CW-1:0] mw_cycles;

    hazard_stall_unit #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .fwd_en       (fwd_en),
        .id_valid     (id_valid),
        .src1         (src1),
        .src2         (src2),
        .two_src      (two_src),
        .EXE_Dest     (EXE_Dest),
        .EXE_WB_en    (EXE_WB_en),
        .EXE_MEM_R_en (EXE_MEM_R_en),
        .MEM_Dest     (MEM_Dest),
        .MEM_WB_en    (MEM_WB_en),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .hazard_stall (hazard_stall),
        .mem_freeze   (mem_freeze),
        .mem_timeout  (mem_timeout),
        .hz_cycles    (hz_cycles),
        .mw_cycles    (mw_cycles)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: freeze edges spent on the current access, sticky timeout, counters
    int w_edges;
    bit m_to;
    int m_hz;
    int m_mw;
    bit e_stall;
    bit e_freeze;

    typedef struct {
        bit       fwd;
        bit       idv;
        logic [3:0] s1;
        logic [3:0] s2;
        bit       two;
        logic [3:0] ed;
        bit       ewb;
        bit       eld;
        logic [3:0] md;
        bit       mwb;
        bit       exp_stall;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // A source needs a stall if it reads a register produced by an instruction whose result cannot be forwarded yet
    function automatic bit model_raw();
        int needs[$];
        int prods[$];
        if (!id_valid) return 1'b0;
        needs.push_back(int'(src1));
        if (two_src) needs.push_back(int'(src2));
        if (fwd_en) begin
            if (EXE_WB_en && EXE_MEM_R_en) prods.push_back(int'(EXE_Dest));
        end else begin
            if (EXE_WB_en) prods.push_back(int'(EXE_Dest));
            if (MEM_WB_en) prods.push_back(int'(MEM_Dest));
        end
        foreach (needs[i]) foreach (prods[j]) if (needs[i] == prods[j]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        w_edges = 0;
        m_to    = 1'b0;
        m_hz    = 0;
        m_mw    = 0;
    endtask

    // Inputs are set at a negedge; checks one cycle and returns at the next negedge
    task automatic step(input string tag);
        #1;
        if (rst) model_reset();
        e_freeze = !rst && (w_edges > 0 || mem_req) && !mem_ready;
        e_stall  = !rst && model_raw() && !e_freeze;
        chk({tag, ".stall"}, 32'(hazard_stall), 32'(e_stall));
        chk({tag, ".freeze"}, 32'(mem_freeze), 32'(e_freeze));
        chk({tag, ".excl"}, 32'(hazard_stall & mem_freeze), 32'd0);
        @(posedge clk);
        if (!rst) begin
            if (e_stall && m_hz < CMAX) m_hz++;
            if (e_freeze) begin
                if (m_mw < CMAX) m_mw++;
                w_edges++;
                if (w_edges >= TO) m_to = 1'b1;
            end else if (mem_ready) begin
                w_edges = 0;
            end
        end
        #1;
        chk({tag, ".timeout"}, 32'(mem_timeout), 32'(m_to));
        chk({tag, ".hz"}, 32'(hz_cycles), 32'(m_hz));
        chk({tag, ".mw"}, 32'(mw_cycles), 32'(m_mw));
        @(negedge clk);
    endtask

    task automatic set_hz(input bit fwd, input bit idv, input logic [3:0] s1, input logic [3:0] s2,
                          input bit two, input logic [3:0] ed, input bit ewb, input bit eld,
                          input logic [3:0] md, input bit mwb);
        fwd_en = fwd; id_valid = idv; src1 = s1; src2 = s2; two_src = two;
        EXE_Dest = ed; EXE_WB_en = ewb; EXE_MEM_R_en = eld; MEM_Dest = md; MEM_WB_en = mwb;
    endtask

    initial begin
        tbl[0]  = '{1, 1, 4'd3, 4'd0, 0, 4'd3, 1, 1, 4'd0, 0, 1};
        tbl[1]  = '{1, 1, 4'd3, 4'd0, 0, 4'd3, 1, 0, 4'd3, 1, 0};
        tbl[2]  = '{0, 1, 4'd1, 4'd5, 0, 4'd9, 0, 0, 4'd5, 1, 0};
        tbl[3]  = '{0, 1, 4'd1, 4'd5, 1, 4'd9, 0, 0, 4'd5, 1, 1};
        tbl[4]  = '{0, 1, 4'd7, 4'd0, 0, 4'd7, 1, 0, 4'd2, 0, 1};
        tbl[5]  = '{1, 0, 4'd3, 4'd0, 0, 4'd3, 1, 1, 4'd0, 0, 0};
        tbl[6]  = '{1, 1, 4'd0, 4'd3, 1, 4'd3, 1, 1, 4'd8, 0, 1};
        tbl[7]  = '{1, 1, 4'd0, 4'd3, 0, 4'd3, 1, 1, 4'd8, 0, 0};
        tbl[8]  = '{1, 1, 4'd3, 4'd0, 0, 4'd3, 0, 1, 4'd8, 0, 0};
        tbl[9]  = '{0, 1, 4'd4, 4'd0, 0, 4'd4, 0, 0, 4'd4, 0, 0};
        tbl[10] = '{0, 1, 4'd5, 4'd0, 0, 4'd9, 1, 0, 4'd5, 1, 1};

        rst = 1'b1;
        set_hz(0, 0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0);
        mem_req = 1'b0;
        mem_ready = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset state, with a live load-use hazard and pending request that must stay masked
        set_hz(1, 1, 4'd3, 4'd0, 0, 4'd3, 1, 1, 4'd0, 0);
        mem_req = 1'b1;
        #1;
        chk("rst.stall", 32'(hazard_stall), 32'd0);
        chk("rst.freeze", 32'(mem_freeze), 32'd0);
        chk("rst.timeout", 32'(mem_timeout), 32'd0);
        chk("rst.hz", 32'(hz_cycles), 32'd0);
        chk("rst.mw", 32'(mw_cycles), 32'd0);
        step("rst");
        mem_req = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            set_hz(tbl[i].fwd, tbl[i].idv, tbl[i].s1, tbl[i].s2, tbl[i].two,
                   tbl[i].ed, tbl[i].ewb, tbl[i].eld, tbl[i].md, tbl[i].mwb);
            #1;
            chk($sformatf("vec%0d", i), 32'(hazard_stall), 32'(tbl[i].exp_stall));
            step($sformatf("vec%0d", i));
            if (i == 0) chk("hz_first", 32'(hz_cycles), 32'd1);
        end

        // Three-cycle SRAM wait
        set_hz(1, 0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0);
        begin
            int mw0;
            mw0 = int'(mw_cycles);
            mem_req = 1'b1;
            mem_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
                #1;
                chk("wait.frz", 32'(mem_freeze), 32'd1);
                step("wait");
            end
            mem_ready = 1'b1;
            #1;
            chk("wait.rdy", 32'(mem_freeze), 32'd0);
            step("wait.rdy");
            chk("wait.mw3", 32'(mw_cycles), 32'(mw0 + 3));
            mem_req = 1'b0;
            mem_ready = 1'b0;
            #1;
            chk("wait.run", 32'(mem_freeze), 32'd0);
            step("wait.run");
        end

        // Load-use hazard hidden by the freeze, exposed on the ready cycle
        set_hz(1, 1, 4'd3, 4'd0, 0, 4'd3, 1, 1, 4'd0, 0);
        mem_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("lu.masked", 32'(hazard_stall), 32'd0);
            step("lu");
        end
        mem_ready = 1'b1;
        #1;
        chk("lu.rdy", 32'(hazard_stall), 32'd1);
        step("lu.rdy");
        mem_req = 1'b0;
        mem_ready = 1'b0;
        set_hz(1, 0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0);
        step("idle");

        // Timeout raised after the 4th freeze edge, sticky past ready, cleared by reset mid-wait
        mem_req = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step("to");
            chk($sformatf("to.edge%0d", i), 32'(mem_timeout), (i >= TO) ? 32'd1 : 32'd0);
        end
        mem_ready = 1'b1;
        step("to.rdy");
        mem_req = 1'b0;
        mem_ready = 1'b0;
        step("to.after");
        chk("to.sticky", 32'(mem_timeout), 32'd1);
        mem_req = 1'b1;
        step("to.rewait");
        step("to.rewait");
        rst = 1'b1;
        #1;
        chk("midrst.freeze", 32'(mem_freeze), 32'd0);
        chk("midrst.timeout", 32'(mem_timeout), 32'd0);
        chk("midrst.mw", 32'(mw_cycles), 32'd0);
        step("midrst");
        rst = 1'b0;
        mem_req = 1'b0;
        #1;
        chk("midrst.run", 32'(mem_freeze), 32'd0);
        step("midrst.run");

        // Counter saturation
        set_hz(1, 1, 4'd3, 4'd0, 0, 4'd3, 1, 1, 4'd0, 0);
        for (int i = 0; i < 260; i++) step("sat.hz");
        chk("sat.hz255", 32'(hz_cycles), 32'd255);
        mem_req = 1'b1;
        for (int i = 0; i < 260; i++) step("sat.mw");
        chk("sat.mw255", 32'(mw_cycles), 32'd255);
        chk("sat.hzhold", 32'(hz_cycles), 32'd255);

        rst = 1'b1;
        step("rnd.rst");
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            set_hz(1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0),
                   4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            mem_req = ($urandom_range(0, 9) < 4);
            mem_ready = ($urandom_range(0, 9) < 3);
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
